// File: rtl/mux4_chk_pkg.sv
// Shared types and helpers for the 4:1 mux output checker.
// Holds the checker FSM encoding, select codes and the reference mux.
package mux4_chk_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;
    localparam logic [1:0] SEL_D = 2'b11;

    // Reference 4:1 mux; sel is {s1, s2} with s1 as the MSB.
    function automatic logic mux4_expect(
        input logic       a,
        input logic       b,
        input logic       c,
        input logic       d,
        input logic [1:0] sel
    );
        logic r;
        r = a;
        unique case (sel)
            SEL_A: r = a;
            SEL_B: r = b;
            SEL_C: r = c;
            SEL_D: r = d;
            default: r = a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mux4_ref_pipe.sv
// Delay line that aligns expected mux values with the DUT output.
// LATENCY=0 is a pure wire; otherwise a LATENCY-deep {exp, vld} shifter.
module mux4_ref_pipe #(
    parameter int LATENCY = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic in_exp,
    input  logic in_vld,
    output logic out_exp,
    output logic out_vld,
    output logic any_vld
);

    if (LATENCY == 0) begin : g_comb
        logic unused_pipe;
        assign unused_pipe = ^{clk, rst_n, flush};
        assign out_exp = in_exp;
        assign out_vld = in_vld;
        assign any_vld = 1'b0;
    end else begin : g_regs
        logic [LATENCY-1:0] exp_q;
        logic [LATENCY-1:0] exp_d;
        logic [LATENCY-1:0] vld_q;
        logic [LATENCY-1:0] vld_d;

        // Shift one slot per cycle; bubbles keep alignment, flush empties all.
        always_comb begin
            exp_d = '0;
            vld_d = '0;
            if (!flush) begin
                exp_d[0] = in_exp;
                vld_d[0] = in_vld;
                for (int i = 1; i < LATENCY; i++) begin
                    exp_d[i] = exp_q[i-1];
                    vld_d[i] = vld_q[i-1];
                end
            end
        end

        // Delay-line storage.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                exp_q <= '0;
                vld_q <= '0;
            end else begin
                exp_q <= exp_d;
                vld_q <= vld_d;
            end
        end

        assign out_exp = exp_q[LATENCY-1];
        assign out_vld = vld_q[LATENCY-1];
        assign any_vld = |vld_q;
    end

endmodule

// File: rtl/mux4_checker.sv
// Self-checking endpoint for the 4:1 mux stimulus path.
// Runs IDLE/RUN/DRAIN/DONE, compares delayed expectations, keeps stats.
module mux4_checker
    import mux4_chk_pkg::*;
#(
    parameter int LATENCY = 0,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             valid,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             d,
    input  logic             s1,
    input  logic             s2,
    input  logic             y,
    output logic             mismatch,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             busy,
    output logic             done,
    output logic             pass
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             mismatch_q, mismatch_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;

    logic exp_bit;
    logic push_vld;
    logic cmp_exp;
    logic cmp_vld;
    logic cmp_en;
    logic pipe_busy;

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v
    );
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign exp_bit  = mux4_expect(a, b, c, d, {s1, s2});
    assign push_vld = valid && (state_q == RUN) && !start;
    assign cmp_en   = cmp_vld
                   && ((state_q == RUN) || (state_q == DRAIN));

    mux4_ref_pipe #(
        .LATENCY(LATENCY)
    ) u_pipe (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (start),
        .in_exp (exp_bit),
        .in_vld (push_vld),
        .out_exp(cmp_exp),
        .out_vld(cmp_vld),
        .any_vld(pipe_busy)
    );

    // Next state, statistics and verdict; start overrides everything.
    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        pass_cnt_d   = pass_cnt_q;
        err_cnt_d    = err_cnt_q;
        mismatch_d   = 1'b0;
        if (start) begin
            state_d      = RUN;
            sample_cnt_d = '0;
            pass_cnt_d   = '0;
            err_cnt_d    = '0;
        end else begin
            unique case (state_q)
                RUN:     if (stop) state_d = DRAIN;
                DRAIN:   if (!pipe_busy) state_d = DONE;
                default: state_d = state_q;
            endcase
            if (push_vld) begin
                sample_cnt_d = sat_inc(sample_cnt_q);
            end
            if (cmp_en) begin
                if (y !== cmp_exp) begin
                    err_cnt_d  = sat_inc(err_cnt_q);
                    mismatch_d = 1'b1;
                end else begin
                    pass_cnt_d = sat_inc(pass_cnt_q);
                end
            end
        end
        busy_d = (state_d == RUN) || (state_d == DRAIN);
        done_d = (state_d == DONE);
        pass_d = done_d
              && (err_cnt_d == '0)
              && (sample_cnt_d != '0);
    end

    // Register FSM state, counters and all outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sample_cnt_q <= '0;
            pass_cnt_q   <= '0;
            err_cnt_q    <= '0;
            mismatch_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            pass_cnt_q   <= pass_cnt_d;
            err_cnt_q    <= err_cnt_d;
            mismatch_q   <= mismatch_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
        end
    end

    assign mismatch   = mismatch_q;
    assign sample_cnt = sample_cnt_q;
    assign pass_cnt   = pass_cnt_q;
    assign err_cnt    = err_cnt_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;

endmodule

// File: tb/tb_mux4_checker.sv
// Scoreboard bench for mux4_checker at LATENCY 0/2 and a 3-bit counter build.
// Each run's expected verdict is queued at start and checked when done rises.
module tb_mux4_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic valid, a, b, c, d, s1, s2;

    logic rst0_n, start0, stop0, y0, mis0, busy0, done0, pass0;
    logic [15:0] sc0, pc0, ec0;
    logic rst2_n, start2, stop2, y2, mis2, busy2, done2, pass2;
    logic [15:0] sc2, pc2, ec2;
    logic rst3_n, start3, stop3, y3, mis3, busy3, done3, pass3;
    logic [2:0] sc3, pc3, ec3;

    mux4_checker #(.LATENCY(0), .CNT_W(16)) u0 (
        .clk(clk), .rst_n(rst0_n), .start(start0), .stop(stop0),
        .valid(valid), .a(a), .b(b), .c(c), .d(d), .s1(s1), .s2(s2),
        .y(y0), .mismatch(mis0), .sample_cnt(sc0), .pass_cnt(pc0),
        .err_cnt(ec0), .busy(busy0), .done(done0), .pass(pass0)
    );

    mux4_checker #(.LATENCY(2), .CNT_W(16)) u2 (
        .clk(clk), .rst_n(rst2_n), .start(start2), .stop(stop2),
        .valid(valid), .a(a), .b(b), .c(c), .d(d), .s1(s1), .s2(s2),
        .y(y2), .mismatch(mis2), .sample_cnt(sc2), .pass_cnt(pc2),
        .err_cnt(ec2), .busy(busy2), .done(done2), .pass(pass2)
    );

    mux4_checker #(.LATENCY(0), .CNT_W(3)) u3 (
        .clk(clk), .rst_n(rst3_n), .start(start3), .stop(stop3),
        .valid(valid), .a(a), .b(b), .c(c), .d(d), .s1(s1), .s2(s2),
        .y(y3), .mismatch(mis3), .sample_cnt(sc3), .pass_cnt(pc3),
        .err_cnt(ec3), .busy(busy3), .done(done3), .pass(pass3)
    );

    typedef struct {
        int id;
        int sc;
        int pc;
        int ec;
        int pv;
        int mc;
    } res_t;

    res_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   mcnt[3];
    logic dp0 = 1'b0, dp2 = 1'b0, dp3 = 1'b0;

    // Vectors (a,b,c,d,s1,s2) and their hand-computed mux outputs.
    logic [5:0] vv[4] = '{6'b100111, 6'b001101, 6'b110110, 6'b101100};
    logic       ye[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    function automatic void chk(input string nm, input int act,
                                input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endfunction

    task automatic push(input int id, input int sc, input int pc,
                        input int ec, input int pv, input int mc);
        res_t e;
        e.id = id; e.sc = sc; e.pc = pc;
        e.ec = ec; e.pv = pv; e.mc = mc;
        sb.push_back(e);
    endtask

    task automatic pop(input int id, input int sc, input int pc,
                       input int ec, input int pv);
        res_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL d%0d_sb_empty: got done, expected none", id);
        end else begin
            e = sb.pop_front();
            chk($sformatf("d%0d_sb_id", id), id, e.id);
            chk($sformatf("d%0d_sample_cnt", id), sc, e.sc);
            chk($sformatf("d%0d_pass_cnt", id), pc, e.pc);
            chk($sformatf("d%0d_err_cnt", id), ec, e.ec);
            chk($sformatf("d%0d_pass", id), pv, e.pv);
            chk($sformatf("d%0d_mismatch_pulses", id), mcnt[id], e.mc);
        end
    endtask

    // Monitor: count mismatch pulses, check results when done rises.
    always @(negedge clk) begin
        if (mis0 === 1'b1) mcnt[0]++;
        if (mis2 === 1'b1) mcnt[1]++;
        if (mis3 === 1'b1) mcnt[2]++;
        if (done0 && !dp0)
            pop(0, int'(sc0), int'(pc0), int'(ec0), int'(pass0));
        if (done2 && !dp2)
            pop(1, int'(sc2), int'(pc2), int'(ec2), int'(pass2));
        if (done3 && !dp3)
            pop(2, int'(sc3), int'(pc3), int'(ec3), int'(pass3));
        dp0 = done0;
        dp2 = done2;
        dp3 = done3;
    end

    function automatic logic dn(input int id);
        return (id == 0) ? done0 : (id == 1) ? done2 : done3;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic vec(input logic [5:0] v);
        {a, b, c, d, s1, s2} = v;
        valid = 1'b1;
    endtask

    task automatic wait_done(input int id, input int lim);
        int n;
        n = 0;
        while (!dn(id) && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("d%0d_done_timeout", id), int'(dn(id)), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        valid = 0; {a, b, c, d, s1, s2} = '0;
        start0 = 0; stop0 = 0; y0 = 0; rst0_n = 0;
        start2 = 0; stop2 = 0; y2 = 0; rst2_n = 0;
        start3 = 0; stop3 = 0; y3 = 0; rst3_n = 0;
        for (int i = 0; i < 3; i++) mcnt[i] = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy0", int'(busy0), 0);
        chk("rst_done0", int'(done0), 0);
        chk("rst_pass0", int'(pass0), 0);
        chk("rst_mis0", int'(mis0), 0);
        chk("rst_cnt0", int'(sc0) + int'(pc0) + int'(ec0), 0);
        chk("rst_busy2", int'(busy2), 0);
        chk("rst_done3", int'(done3), 0);
        tick();
        rst0_n = 1; rst2_n = 1; rst3_n = 1;

        // LATENCY=0, all vectors match.
        tick();
        push(0, 4, 4, 0, 1, 0);
        start0 = 1; mcnt[0] = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            start0 = 0;
            vec(vv[i]);
            y0 = ye[i];
        end
        tick(); valid = 0; stop0 = 1;
        tick(); stop0 = 0;
        @(negedge clk);
        chk("d0_drain_busy", int'(busy0), 1);
        chk("d0_drain_done", int'(done0), 0);
        @(negedge clk);
        chk("d0_drain_one_cycle", int'(done0), 1);

        // LATENCY=0, first vector wrong.
        tick();
        push(0, 4, 3, 1, 0, 1);
        start0 = 1; mcnt[0] = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            start0 = 0;
            vec(vv[i]);
            y0 = (i == 0) ? 1'b0 : ye[i];
        end
        tick(); valid = 0; stop0 = 1;
        tick(); stop0 = 0;
        wait_done(0, 10);

        // LATENCY=2, y delayed by two cycles, stop with last vector.
        tick();
        push(1, 4, 4, 0, 1, 0);
        start2 = 1; mcnt[1] = 0;
        for (int t = 0; t < 4; t++) begin
            tick();
            start2 = 0;
            vec(vv[t]);
            stop2 = (t == 3);
            y2 = (t >= 2) ? ye[t-2] : 1'b0;
        end
        tick(); valid = 0; stop2 = 0; y2 = ye[2];
        @(negedge clk);
        chk("d2_done_k0", int'(done2), 0);
        tick(); y2 = ye[3];
        @(negedge clk);
        chk("d2_done_k1", int'(done2), 0);
        @(negedge clk);
        chk("d2_done_k2", int'(done2), 0);
        @(negedge clk);
        chk("d2_done_k3", int'(done2), 1);

        // Restart in RUN clears counters; start+stop stays in RUN.
        tick();
        start0 = 1; mcnt[0] = 0;
        tick(); start0 = 0; vec(vv[0]); y0 = 1'b0;
        tick(); valid = 0;
        @(negedge clk);
        chk("d0_pre_restart_err", int'(ec0), 1);
        tick();
        push(0, 0, 0, 0, 0, 0);
        start0 = 1; mcnt[0] = 0;
        tick(); start0 = 0;
        @(negedge clk);
        chk("d0_restart_cnts", int'(sc0) + int'(pc0) + int'(ec0), 0);
        chk("d0_restart_busy", int'(busy0), 1);
        chk("d0_restart_done", int'(done0), 0);
        tick(); start0 = 1; stop0 = 1;
        tick(); start0 = 0; stop0 = 0;
        @(negedge clk);
        chk("d0_startstop_busy", int'(busy0), 1);
        @(negedge clk);
        chk("d0_startstop_run", int'(done0), 0);
        chk("d0_startstop_busy2", int'(busy0), 1);
        tick(); stop0 = 1;
        tick(); stop0 = 0;
        wait_done(0, 10);

        // CNT_W=3, ten failing samples saturate at 7.
        tick();
        push(2, 7, 0, 7, 0, 10);
        start3 = 1; mcnt[2] = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            start3 = 0;
            vec(vv[i % 4]);
            y3 = !ye[i % 4];
        end
        tick(); valid = 0; stop3 = 1;
        tick(); stop3 = 0;
        wait_done(2, 10);

        // LATENCY=2, async reset in DRAIN; stop ignored afterwards.
        tick();
        start2 = 1;
        tick(); start2 = 0; vec(vv[0]); y2 = 1'b0;
        tick(); vec(vv[1]); stop2 = 1;
        tick(); valid = 0; stop2 = 0;
        @(negedge clk);
        chk("d2_pre_rst_busy", int'(busy2), 1);
        chk("d2_pre_rst_samples", int'(sc2), 2);
        #1 rst2_n = 0;
        #1;
        chk("d2_arst_busy", int'(busy2), 0);
        chk("d2_arst_done", int'(done2), 0);
        chk("d2_arst_pass", int'(pass2), 0);
        chk("d2_arst_mis", int'(mis2), 0);
        chk("d2_arst_cnts", int'(sc2) + int'(pc2) + int'(ec2), 0);
        tick(); rst2_n = 1;
        tick(); stop2 = 1;
        tick(); stop2 = 0;
        @(negedge clk);
        chk("d2_idle_stop_done", int'(done2), 0);
        chk("d2_idle_stop_busy", int'(busy2), 0);
        @(negedge clk);
        chk("d2_idle_stop_done2", int'(done2), 0);

        tick();
        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux4_checker.md
# mux4_checker

Synthesizable output checker that sits directly downstream of the 4:1 mux under test. Each cycle it samples the same a/b/c/d/s1/s2 stimulus the mux sees and computes the expected output. It compares that against the mux output y after a configurable DUT latency, and keeps mismatch, pass and sample counters plus a pass/fail verdict. Benches and FPGA smoke builds use it as the self-checking endpoint of the mux stimulus path.

## Interface
- LATENCY, 0: DUT latency in clock cycles from stimulus sample to valid y (0..8).
- CNT_W, 16: width of each statistics counter.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous and active-low; one clock, async active-low reset, fixed.
- start  in  1  one-cycle pulse that clears statistics and enters RUN.
- stop  in  1  one-cycle pulse that ends the run; in-flight samples drain first.
- valid  in  1  stimulus on a..s2 is meaningful this cycle.
- a, b, c, d  in  1 each  mux data inputs, tapped from the stimulus bus.
- s1, s2  in  1 each  mux selects; s1 is the MSB.
- y  in  1  mux output under check.
- mismatch  out  1  registered one-cycle pulse per failed compare.
- sample_cnt, pass_cnt, err_cnt  out  CNT_W each  saturating counters.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  high in DONE.
- pass  out  1  valid only in DONE; 1 iff err_cnt==0 and sample_cnt>0.

## Operation
- Expected value: {s1,s2} 00->a, 01->b, 10->c, 11->d.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE -start-> RUN.
  - RUN -stop-> DRAIN.
  - DRAIN -> DONE when the delay line holds no valid entry. With LATENCY=0, DRAIN lasts exactly one cycle.
  - DONE -start-> RUN.
- start in any state clears all counters and the delay line, then enters RUN. start and stop in the same cycle: start wins.
- Sample rule: valid && state==RUN pushes {exp, 1} into the delay line, and sample_cnt increments.
- valid in IDLE, DRAIN or DONE is ignored and pushes a bubble.
- Compare rule: when the delay-line output entry is valid, compare it with the current y.
  - Equal: pass_cnt increments.
  - Different: err_cnt increments and mismatch pulses.
  - Compares happen in RUN and DRAIN.
- Counters saturate at 2^CNT_W-1 and never wrap.
- X or Z on y during a compare counts as a mismatch. Use the `!==` semantic in simulation; synthesis treats y as 2-state.
- stop in IDLE or DONE is ignored.

## Timing
- Reset values: all counters 0, mismatch=0, busy=0, done=0, pass=0, state=IDLE, delay line all-invalid.
- Reset mid-run discards in-flight samples; no verdict is produced.
- LATENCY=0: the expected value is compared against y in the same cycle it is sampled. Counters and mismatch update at that rising edge and are visible the next cycle.
- LATENCY=N: a sample at edge k is compared against y present before edge k+N. Results are visible after edge k+N.
- The delay line shifts every cycle regardless of valid, so bubbles preserve alignment.
- stop at edge k: samples with valid at edge k are still taken. DRAIN lasts N cycles and done rises after edge k+N+1.
- pass and done are registered and stable until the next start or reset.

## Structure
- Package mux4_chk_pkg holds:
  - the state_t enum (IDLE, RUN, DRAIN, DONE);
  - select-code localparams SEL_A..SEL_D (2'b00..2'b11);
  - the function mux4_expect(a, b, c, d, sel) returning 1 bit.
- Sub-module mux4_ref_pipe: a parameterized LATENCY-deep shift register of {exp, vld} with a synchronous flush input. LATENCY=0 degenerates to a combinational pass-through.
- Top module: FSM, compare logic, counters, verdict.

## Test plan
- Reset, LATENCY=0. Steps: start; apply 4 valid vectors (a,b,c,d,s1,s2) = (1,0,0,1,1,1), (0,0,1,1,0,1), (1,1,0,1,1,0), (1,0,1,1,0,0), with y = 1, 0, 0, 1; then stop. Required: sample_cnt=4, pass_cnt=4, err_cnt=0, done=1, pass=1, mismatch never high.
- Same vectors, but y forced to 0 on the first vector. Required: one mismatch pulse, err_cnt=1, pass_cnt=3, pass=0.
- LATENCY=2, y delayed by 2 cycles. Required: all pass. Stop right after the last vector; done rises exactly 3 cycles after stop and pass_cnt=4.
- Issue start while in RUN with err_cnt=1. Required: all counters read 0 the next cycle and the state is RUN. start and stop together: stays RUN.
- Set CNT_W=3 and run 10 failing samples. Required: err_cnt saturates at 7 and mismatch pulses 10 times.
- Assert rst_n low mid-DRAIN with LATENCY=2. Required: all outputs return to reset values immediately (async). After reset, stop is ignored in IDLE and done stays 0.
